// File: rtl/ptw_pkg.sv
// Shared types for the page table walker.
//   riscv      : Sv39 page table entry layout
//   ariane_pkg : TLB fill record and page table geometry
//   ptw_pkg    : walk level encoding and VPN field selection
// Optional feature macro used by the walker: PTW_AD_CHECK_EN.
package riscv;
  typedef struct packed {
    logic [9:0]  reserved;
    logic [43:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;
endpackage

package ariane_pkg;
  localparam int unsigned PT_LEVELS      = 3;
  localparam int unsigned PTE_BYTES      = 8;
  // Widest ASID the fill record carries; narrower ASIDs are zero-extended.
  localparam int unsigned ASID_MAX_WIDTH = 16;

  typedef struct packed {
    logic                      valid;
    logic                      is_2M;
    logic                      is_1G;
    logic [26:0]               vpn;
    logic [ASID_MAX_WIDTH-1:0] asid;
    riscv::pte_t               content;
  } tlb_update_t;
endpackage

package ptw_pkg;
  typedef enum logic [1:0] {
    LVL_1G = 2'd0,
    LVL_2M = 2'd1,
    LVL_4K = 2'd2
  } level_e;

  // VPN slice that indexes the page table at the given level.
  function automatic logic [8:0] vpn_field(input logic [63:0] va, input level_e lvl);
    case (lvl)
      LVL_1G:  return va[38:30];
      LVL_2M:  return va[29:21];
      default: return va[20:12];
    endcase
  endfunction
endpackage

// File: rtl/ptw_if.sv
// PTE read port between the walker (master) and the memory side (slave).
// Handshake: the master holds mem_req_o high with mem_addr_o stable until a
// cycle in which mem_gnt_i is also high; that cycle transfers the request.
// Each granted request receives exactly one mem_rvalid_i pulse carrying
// mem_rdata_i in a later cycle; rvalid cannot be back-pressured.
interface ptw_if;
  logic        mem_req_o;
  logic [55:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [63:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/ptw.sv
// Sv39 hardware page table walker: resolves a TLB miss into a TLB fill or a
// page fault by reading up to three PTEs. Defining PTW_AD_CHECK_EN makes a
// leaf with A clear (or D clear on a store) fault instead of filling.
module ptw
  import ariane_pkg::*;
  import ptw_pkg::*;
#(
  parameter int unsigned ASID_WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  walk_req_i,
  input  logic [63:0]           walk_vaddr_i,
  input  logic [ASID_WIDTH-1:0] walk_asid_i,
  input  logic                  walk_is_store_i,
  input  logic [43:0]           satp_ppn_i,
  output logic                  walk_busy_o,
  ptw_if.master                 mem,
  output tlb_update_t           update_o,
  output logic                  page_fault_o,
  output logic [63:0]           fault_vaddr_o,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE            = 3'd0,
    WAIT_GRANT      = 3'd1,
    PTE_LOOKUP      = 3'd2,
    PROPAGATE_ERROR = 3'd3,
    WAIT_RVALID     = 3'd4
  } state_e;

  localparam int unsigned PTE_OFS = $clog2(PTE_BYTES);

  state_e                state_q, state_d;
  level_e                level_q, level_d;
  logic [63:0]           vaddr_q, vaddr_d;
  logic [ASID_WIDTH-1:0] asid_q, asid_d;
  logic                  store_q, store_d;
  logic [55:0]           addr_q, addr_d;
  tlb_update_t           update_q, update_d;

  riscv::pte_t pte;
  level_e      next_level;
  logic        leaf, misaligned, leaf_fault, last_level;

  assign pte        = riscv::pte_t'(mem.mem_rdata_i);
  assign leaf       = pte.r | pte.x;
  assign last_level = (level_q == level_e'(2'(PT_LEVELS - 1)));
  assign next_level = (level_q == LVL_1G) ? LVL_2M : LVL_4K;
  // Superpage leaves must point at a naturally aligned physical region.
  assign misaligned = (level_q == LVL_1G) ? (pte.ppn[17:0] != 18'd0) :
                      (level_q == LVL_2M) ? (pte.ppn[8:0]  != 9'd0)  : 1'b0;

  // Permission checks applied to a valid leaf PTE.
  always_comb begin
    leaf_fault = misaligned | (store_q & ~pte.w);
`ifdef PTW_AD_CHECK_EN
    leaf_fault = leaf_fault | ~pte.a | (store_q & ~pte.d);
`endif
  end

  // Next-state logic for the walk; update_d is a one-cycle fill pulse.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    vaddr_d  = vaddr_q;
    asid_d   = asid_q;
    store_d  = store_q;
    addr_d   = addr_q;
    update_d = '0;
    unique case (state_q)
      IDLE: begin
        if (walk_req_i && !flush_i) begin
          vaddr_d = walk_vaddr_i;
          asid_d  = walk_asid_i;
          store_d = walk_is_store_i;
          level_d = LVL_1G;
          // Non-canonical addresses fault without touching memory.
          if (walk_vaddr_i[63:39] != {25{walk_vaddr_i[38]}}) begin
            state_d = PROPAGATE_ERROR;
          end else begin
            addr_d  = {satp_ppn_i, walk_vaddr_i[38:30], {PTE_OFS{1'b0}}};
            state_d = WAIT_GRANT;
          end
        end
      end
      WAIT_GRANT: begin
        if (flush_i) begin
          // A granted request still owes a response that must be drained.
          state_d = mem.mem_gnt_i ? WAIT_RVALID : IDLE;
        end else if (mem.mem_gnt_i) begin
          state_d = PTE_LOOKUP;
        end
      end
      PTE_LOOKUP: begin
        if (mem.mem_rvalid_i) begin
          if (flush_i) begin
            state_d = IDLE;
          end else if (!pte.v || (!pte.r && pte.w)) begin
            state_d = PROPAGATE_ERROR;
          end else if (leaf) begin
            if (leaf_fault) begin
              state_d = PROPAGATE_ERROR;
            end else begin
              update_d.valid   = 1'b1;
              update_d.is_1G   = (level_q == LVL_1G);
              update_d.is_2M   = (level_q == LVL_2M);
              update_d.vpn     = vaddr_q[38:12];
              update_d.asid    = ASID_MAX_WIDTH'(asid_q);
              update_d.content = pte;
              state_d          = IDLE;
            end
          end else if (last_level) begin
            state_d = PROPAGATE_ERROR;
          end else begin
            level_d = next_level;
            addr_d  = {pte.ppn, vpn_field(vaddr_q, next_level), {PTE_OFS{1'b0}}};
            state_d = WAIT_GRANT;
          end
        end else if (flush_i) begin
          state_d = WAIT_RVALID;
        end
      end
      PROPAGATE_ERROR: state_d = IDLE;
      WAIT_RVALID: begin
        if (mem.mem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything, including a walk in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      level_q  <= LVL_1G;
      vaddr_q  <= '0;
      asid_q   <= '0;
      store_q  <= 1'b0;
      addr_q   <= '0;
      update_q <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      vaddr_q  <= vaddr_d;
      asid_q   <= asid_d;
      store_q  <= store_d;
      addr_q   <= addr_d;
      update_q <= update_d;
    end
  end

  assign walk_busy_o    = (state_q != IDLE);
  assign mem.mem_req_o  = (state_q == WAIT_GRANT);
  assign mem.mem_addr_o = addr_q;
  assign update_o       = update_q;
  assign page_fault_o   = (state_q == PROPAGATE_ERROR);
  assign fault_vaddr_o  = vaddr_q;
  assign dbg_state      = state_q;

endmodule
